// File: rtl/max7219_frame_scheduler.sv
// Double-buffered frame scheduler with rate-limited swaps and an intensity fade sequencer.
// Optional copy-on-swap behaviour: define MAX7219_FRAME_SCHEDULER_COPY_ON_SWAP_EN.
module max7219_frame_scheduler #(
    parameter int SEG_ROWS         = 1,
    parameter int SEG_COLS         = 2,
    parameter int MIN_FRAME_CYCLES = 4096,
    parameter int FADE_STEP_CYCLES = 1024,
    localparam int YSIZE = SEG_ROWS * 8,
    localparam int XSIZE = SEG_COLS * 8,
    localparam int XW    = $clog2(XSIZE),
    localparam int YW    = $clog2(YSIZE),
    localparam int NSEG  = SEG_ROWS * SEG_COLS
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst,
    input  logic                   i_Wr_Valid,
    output logic                   o_Wr_Ready,
    input  logic [XW-1:0]          i_Wr_X,
    input  logic [YW-1:0]          i_Wr_Y,
    input  logic [1:0]             i_Wr_Op,
    input  logic                   i_Swap_Req,
    output logic                   o_Swap_Ack,
    input  logic [3:0]             i_Target_Intensity,
    output logic [YSIZE*XSIZE-1:0] o_FrameBuf,
    output logic [NSEG*16-1:0]     o_Intensity,
    output logic                   o_Busy
);

    localparam int TW = $clog2(MIN_FRAME_CYCLES + 1);
    localparam int FW = (FADE_STEP_CYCLES > 1) ? $clog2(FADE_STEP_CYCLES) : 1;

`ifdef MAX7219_FRAME_SCHEDULER_COPY_ON_SWAP_EN
    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_COPY} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_CLEAR} state_t;
`endif

    // Row YSIZE-1-y, bit XSIZE-1-x, so flattening puts pixel (0,0) at the MSB.
    typedef logic [YSIZE-1:0][XSIZE-1:0] frame_t;

    state_t          state_q, state_d;
    logic [YW-1:0]   row_q, row_d;
    logic            front_sel_q, front_sel_d;
    frame_t          buf0_q, buf0_d, buf1_q, buf1_d;
    frame_t          frame_q, frame_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            ack_q, ack_d;
    logic [FW-1:0]   fcnt_q, fcnt_d;
    logic [3:0]      level_q, level_d;

    frame_t          back_cur, front_cur, back_nx;
    logic            wr_fire, grant, in_range, wrap;
    logic [YW-1:0]   wr_row, st_row;
    logic [XW-1:0]   wr_col;

    always_comb begin
        back_cur    = front_sel_q ? buf0_q : buf1_q;
        front_cur   = front_sel_q ? buf1_q : buf0_q;
        back_nx     = back_cur;
        state_d     = state_q;
        row_d       = row_q;
        front_sel_d = front_sel_q;

        wr_fire  = i_Wr_Valid && (state_q == S_IDLE);
        grant    = i_Swap_Req && (state_q == S_IDLE) && (timer_q >= TW'(MIN_FRAME_CYCLES));
        in_range = (32'(i_Wr_X) < XSIZE) && (32'(i_Wr_Y) < YSIZE);
        wr_row   = YW'(YSIZE - 1) - i_Wr_Y;
        wr_col   = XW'(XSIZE - 1) - i_Wr_X;
        st_row   = YW'(YSIZE - 1) - row_q;

        case (state_q)
            S_IDLE: begin
                if (wr_fire) begin
                    if (i_Wr_Op == 2'b11) begin
                        state_d = S_CLEAR;
                        row_d   = '0;
                    end else if (in_range) begin
                        case (i_Wr_Op)
                            2'b00:   back_nx[wr_row][wr_col] = 1'b0;
                            2'b01:   back_nx[wr_row][wr_col] = 1'b1;
                            default: back_nx[wr_row][wr_col] = ~back_cur[wr_row][wr_col];
                        endcase
                    end
                end
                if (grant) begin
                    front_sel_d = ~front_sel_q;
`ifdef MAX7219_FRAME_SCHEDULER_COPY_ON_SWAP_EN
                    state_d = S_COPY;
                    row_d   = '0;
`endif
                end
            end
            S_CLEAR: begin
                back_nx[st_row] = '0;
                row_d = row_q + YW'(1);
                if (row_q == YW'(YSIZE - 1)) state_d = S_IDLE;
            end
`ifdef MAX7219_FRAME_SCHEDULER_COPY_ON_SWAP_EN
            S_COPY: begin
                back_nx[st_row] = front_cur[st_row];
                row_d = row_q + YW'(1);
                if (row_q == YW'(YSIZE - 1)) state_d = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // The selected back buffer takes the update; the swap toggle is applied afterwards.
        buf0_d = front_sel_q ? back_nx : buf0_q;
        buf1_d = front_sel_q ? buf1_q : back_nx;

        frame_d = front_cur;
        ack_d   = grant;

        // The grant cycle counts as the first cycle of the new frame period.
        if (grant)
            timer_d = TW'(1);
        else if (timer_q >= TW'(MIN_FRAME_CYCLES))
            timer_d = timer_q;
        else
            timer_d = timer_q + TW'(1);

        wrap    = (fcnt_q == FW'(FADE_STEP_CYCLES - 1));
        fcnt_d  = wrap ? '0 : fcnt_q + FW'(1);
        level_d = level_q;
        if (wrap) begin
            if (level_q < i_Target_Intensity)
                level_d = level_q + 4'd1;
            else if (level_q > i_Target_Intensity)
                level_d = level_q - 4'd1;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            front_sel_q <= 1'b0;
            buf0_q      <= '0;
            buf1_q      <= '0;
            frame_q     <= '0;
            timer_q     <= TW'(MIN_FRAME_CYCLES);
            ack_q       <= 1'b0;
            fcnt_q      <= '0;
            level_q     <= 4'd0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            front_sel_q <= front_sel_d;
            buf0_q      <= buf0_d;
            buf1_q      <= buf1_d;
            frame_q     <= frame_d;
            timer_q     <= timer_d;
            ack_q       <= ack_d;
            fcnt_q      <= fcnt_d;
            level_q     <= level_d;
        end
    end

    assign o_Wr_Ready  = (state_q == S_IDLE);
    assign o_Busy      = (state_q != S_IDLE);
    assign o_Swap_Ack  = ack_q;
    assign o_FrameBuf  = frame_q;
    assign o_Intensity = {NSEG{12'h000, level_q}};

endmodule

// File: tb/tb_max7219_frame_scheduler.sv
// Directed bench for max7219_frame_scheduler: reset, draw/swap, rate limit, clear, edge cases, fade.
// Uses a 1x3 segment array so an out-of-range x coordinate is expressible on the port.
module tb_max7219_frame_scheduler;

    localparam int XS = 24;
    localparam int YS = 8;
    localparam int NP = XS * YS;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid;
    logic          ready;
    logic [4:0]    x;
    logic [2:0]    y;
    logic [1:0]    op;
    logic          req;
    logic          ack;
    logic [3:0]    tgt;
    logic [NP-1:0] frame;
    logic [47:0]   inten;
    logic          busy;

    int checks = 0;
    int errors = 0;

    max7219_frame_scheduler #(
        .SEG_ROWS(1), .SEG_COLS(3), .MIN_FRAME_CYCLES(16), .FADE_STEP_CYCLES(4)
    ) dut (
        .i_Clk(clk), .i_Rst(rst), .i_Wr_Valid(valid), .o_Wr_Ready(ready),
        .i_Wr_X(x), .i_Wr_Y(y), .i_Wr_Op(op), .i_Swap_Req(req), .o_Swap_Ack(ack),
        .i_Target_Intensity(tgt), .o_FrameBuf(frame), .o_Intensity(inten), .o_Busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ack(input int limit, output int n, output bit got);
        n = 0;
        got = 1'b0;
        while (n < limit && !got) begin
            @(negedge clk);
            n++;
            if (ack) got = 1'b1;
        end
    endtask

    task automatic wait_level(input logic [3:0] v, input int limit, output bit got);
        got = 1'b0;
        for (int k = 0; k < limit && !got; k++) begin
            @(negedge clk);
            if (inten[3:0] == v) got = 1'b1;
        end
    endtask

    function automatic logic [47:0] exp_int(input logic [3:0] v);
        return {3{12'h000, v}};
    endfunction

    function automatic int pix(input int px, input int py);
        return NP - 1 - (py * XS + px);
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NP-1:0] e;
        int  n, low_cnt, busy_ack, ack_k;
        bit  got;

        rst = 1'b0; valid = 1'b0; x = '0; y = '0; op = '0; req = 1'b0; tgt = 4'd0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_frame", frame, '0);
        chk("rst_int", inten, '0);
        chk("rst_ready", ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ack", ack, 1'b0);

        // Diagonal draw into the back buffer, then swap.
        for (int i = 0; i < 8; i++) begin
            valid = 1'b1; x = 5'(i); y = 3'(i); op = 2'b01;
            @(negedge clk);
        end
        valid = 1'b0;
        chk("pre_swap_frame", frame, '0);
        req = 1'b1;
        wait_ack(4, n, got);
        chk("ack1_seen", got, 1'b1);
        chk("ack1_latency", n, 1);
        req = 1'b0;
        chk("frame_at_ack", frame, '0);
        @(negedge clk);
        chk("ack1_one_pulse", ack, 1'b0);
        e = '0;
        for (int i = 0; i < 8; i++) e[pix(i, i)] = 1'b1;
        chk("diag_frame", frame, e);

        // Request again the cycle after the ack: next ack 16 cycles after the previous.
        req = 1'b1;
        wait_ack(30, n, got);
        chk("ack2_seen", got, 1'b1);
        chk("rate_gap", n + 1, 16);
        req = 1'b0;
        @(negedge clk);
        chk("frame_after_swap2", frame, '0);

        // Clear the back buffer (holds the diagonal) and request a swap during CLEAR.
        repeat (20) @(negedge clk);
        valid = 1'b1; op = 2'b11;
        @(negedge clk);
        valid = 1'b0; op = 2'b00; req = 1'b1;
        chk("clear_busy", busy, 1'b1);
        low_cnt = 0; busy_ack = 0; ack_k = 0;
        for (int k = 1; k <= 12; k++) begin
            if (k > 1) @(negedge clk);
            if (!ready) low_cnt++;
            if (ack && !ready) busy_ack++;
            if (ack && ack_k == 0) begin
                ack_k = k;
                req = 1'b0;
            end
        end
        chk("clear_ready_low", low_cnt, 8);
        chk("clear_no_ack", busy_ack, 0);
        chk("clear_ack_cycle", ack_k, 10);
        chk("clear_frame", frame, '0);

        // Out-of-range write is dropped; a toggle in the grant cycle shows after the swap.
        repeat (5) @(negedge clk);
        valid = 1'b1; x = 5'd24; y = 3'd2; op = 2'b01;
        @(negedge clk);
        valid = 1'b0;
        repeat (20) @(negedge clk);
        valid = 1'b1; x = 5'd5; y = 3'd3; op = 2'b10; req = 1'b1;
        @(negedge clk);
        chk("edge_ack", ack, 1'b1);
        chk("edge_ready_across_swap", ready, 1'b1);
        valid = 1'b0; req = 1'b0;
        @(negedge clk);
        e = '0;
        e[pix(5, 3)] = 1'b1;
        chk("edge_frame", frame, e);

        // Fade up to 3, then down to 1.
        tgt = 4'd3;
        wait_level(4'd1, 8, got);
        chk("fade_reach1", got, 1'b1);
        chk("fade_int1", inten, exp_int(4'd1));
        repeat (3) @(negedge clk);
        chk("fade_hold1", inten, exp_int(4'd1));
        @(negedge clk);
        chk("fade_int2", inten, exp_int(4'd2));
        repeat (4) @(negedge clk);
        chk("fade_int3", inten, exp_int(4'd3));
        repeat (8) @(negedge clk);
        chk("fade_hold3", inten, exp_int(4'd3));
        tgt = 4'd1;
        wait_level(4'd2, 8, got);
        chk("fade_down2", got, 1'b1);
        repeat (3) @(negedge clk);
        chk("fade_hold2", inten, exp_int(4'd2));
        @(negedge clk);
        chk("fade_down1", inten, exp_int(4'd1));
        repeat (8) @(negedge clk);
        chk("fade_hold_final", inten, exp_int(4'd1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
